// File: rtl/rstreq_ctrl.sv
// Reset request controller: debounced button, watchdog and keyed software
// triggers produce one fixed-length rstreq pulse with the winning cause recorded.
module rstreq_ctrl #(
  parameter int DEBOUNCE_BITS = 16,
  parameter int PULSE_LEN     = 8,
  parameter int WDT_BITS      = 24
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       btn_rstn,
  input  logic       sw_rst_req,
  input  logic [7:0] sw_rst_key,
  input  logic       wdt_enable,
  input  logic       wdt_kick,
  output logic       rstreq,
  output logic [1:0] rst_cause,
  output logic       busy
);
  localparam logic [7:0] SW_KEY       = 8'hA5;
  localparam logic [7:0] PULSE_LAST   = 8'(PULSE_LEN - 1);
  localparam logic [7:0] HOLDOFF_LAST = 8'd15;
  localparam logic [1:0] CAUSE_BTN    = 2'b01;
  localparam logic [1:0] CAUSE_WDT    = 2'b10;
  localparam logic [1:0] CAUSE_SW     = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  logic                     r_btn_meta;
  logic                     r_btn_sync;
  logic                     r_btn_db;
  logic [DEBOUNCE_BITS-1:0] r_db_cnt;
  logic [WDT_BITS-1:0]      r_wdt_cnt;
  state_t                   r_state;
  state_t                   w_state_next;
  logic [7:0]               r_cnt;
  logic [7:0]               w_cnt_next;
  logic [1:0]               r_cause;
  logic [1:0]               w_cause_next;
  logic                     r_rstreq;
  logic                     w_rstreq_next;
  logic                     r_busy;
  logic                     w_db_full;
  logic                     w_btn_trig;
  logic                     w_wdt_trig;
  logic                     w_sw_trig;
  logic                     w_any_trig;

  assign w_db_full  = &r_db_cnt;
  // The button fires on the very cycle the debounced level commits to low.
  assign w_btn_trig = (r_btn_sync != r_btn_db) && w_db_full && !r_btn_sync;
  assign w_wdt_trig = (r_state == S_IDLE) && (&r_wdt_cnt);
  assign w_sw_trig  = sw_rst_req && (sw_rst_key == SW_KEY);
  assign w_any_trig = w_btn_trig || w_wdt_trig || w_sw_trig;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_btn_meta <= 1'b1;
      r_btn_sync <= 1'b1;
      r_btn_db   <= 1'b1;
      r_db_cnt   <= '0;
    end else begin
      r_btn_meta <= btn_rstn;
      r_btn_sync <= r_btn_meta;
      if (r_btn_sync == r_btn_db) begin
        r_db_cnt <= '0;
      end else if (w_db_full) begin
        r_btn_db <= r_btn_sync;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DEBOUNCE_BITS'(1);
      end
    end
  end

  // Cleared on the trigger edge too, so no stale count survives into ASSERT.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wdt_cnt <= '0;
    end else if ((r_state != S_IDLE) || w_any_trig || !wdt_enable || wdt_kick) begin
      r_wdt_cnt <= '0;
    end else if (!(&r_wdt_cnt)) begin
      r_wdt_cnt <= r_wdt_cnt + WDT_BITS'(1);
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_cause_next  = r_cause;
    w_rstreq_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_trig) begin
          w_state_next  = S_ASSERT;
          w_cnt_next    = PULSE_LAST;
          w_rstreq_next = 1'b1;
          if (w_btn_trig)      w_cause_next = CAUSE_BTN;
          else if (w_wdt_trig) w_cause_next = CAUSE_WDT;
          else                 w_cause_next = CAUSE_SW;
        end
      end
      S_ASSERT: begin
        if (r_cnt == 8'd0) begin
          w_state_next = S_HOLDOFF;
          w_cnt_next   = 8'd0;
        end else begin
          w_cnt_next    = r_cnt - 8'd1;
          w_rstreq_next = 1'b1;
        end
      end
      S_HOLDOFF: begin
        // Counts consecutive released cycles; a held button restarts it.
        if (!r_btn_db) begin
          w_cnt_next = 8'd0;
        end else if (r_cnt == HOLDOFF_LAST) begin
          w_state_next = S_IDLE;
          w_cnt_next   = 8'd0;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_cause  <= 2'b00;
      r_rstreq <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_cause  <= w_cause_next;
      r_rstreq <= w_rstreq_next;
      r_busy   <= (w_state_next != S_IDLE);
    end
  end

  assign rstreq    = r_rstreq;
  assign rst_cause = r_cause;
  assign busy      = r_busy;

endmodule

// File: tb/tb_rstreq_ctrl.sv
// Bench for rstreq_ctrl: directed scenarios, a cycle model compared every
// cycle, and literal expectations on latencies, pulse lengths and causes.
module tb_rstreq_ctrl;
  localparam int DB = 4;
  localparam int PL = 8;
  localparam int WB = 6;
  localparam int WDT_MAX = (1 << WB) - 1;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       btn_rstn = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic [7:0] sw_rst_key = 8'h00;
  logic       wdt_enable = 1'b0;
  logic       wdt_kick = 1'b0;
  logic       rstreq;
  logic [1:0] rst_cause;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 0;
  int hi_cnt = 0;
  int rise_cnt = 0;
  logic prev_rq = 1'b0;

  always #5 clk = ~clk;

  rstreq_ctrl #(.DEBOUNCE_BITS(DB), .PULSE_LEN(PL), .WDT_BITS(WB)) dut (
    .clk(clk), .resetn(resetn), .btn_rstn(btn_rstn),
    .sw_rst_req(sw_rst_req), .sw_rst_key(sw_rst_key),
    .wdt_enable(wdt_enable), .wdt_kick(wdt_kick),
    .rstreq(rstreq), .rst_cause(rst_cause), .busy(busy)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 pulsing, 2 holdoff.
  int m_sync0, m_sync1, m_db, m_run, m_wdt, m_phase, m_left, m_rel, m_cause;
  always @(posedge clk or negedge resetn) begin : model
    int old_db;
    bit t_btn, t_wdt, t_sw, t_any;
    if (!resetn) begin
      m_sync0 = 1; m_sync1 = 1; m_db = 1; m_run = 0; m_wdt = 0;
      m_phase = 0; m_left = 0; m_rel = 0; m_cause = 0;
    end else begin
      old_db = m_db;
      t_btn = 0;
      if (m_sync1 != m_db) begin
        m_run++;
        if (m_run == (1 << DB)) begin
          m_db = m_sync1;
          m_run = 0;
          t_btn = (m_db == 0);
        end
      end else begin
        m_run = 0;
      end
      m_sync1 = m_sync0;
      m_sync0 = int'(btn_rstn);
      t_wdt = (m_phase == 0) && (m_wdt == WDT_MAX);
      t_sw  = sw_rst_req && (sw_rst_key == 8'hA5);
      t_any = t_btn || t_wdt || t_sw;
      if (m_phase == 0 && wdt_enable && !wdt_kick && !t_any)
        m_wdt = (m_wdt < WDT_MAX) ? m_wdt + 1 : WDT_MAX;
      else
        m_wdt = 0;
      if (m_phase == 0) begin
        if (t_any) begin
          m_cause = t_btn ? 1 : (t_wdt ? 2 : 3);
          m_phase = 1;
          m_left = PL;
        end
      end else if (m_phase == 1) begin
        m_left--;
        if (m_left == 0) begin
          m_phase = 2;
          m_rel = 0;
        end
      end else begin
        if (old_db != 0) begin
          m_rel++;
          if (m_rel == 16) m_phase = 0;
        end else begin
          m_rel = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_rstreq", int'(rstreq), int'(m_phase == 1));
      check("model_busy", int'(busy), int'(m_phase != 0));
      check("model_cause", int'(rst_cause), m_cause);
    end
    if (rstreq === 1'b1) hi_cnt++;
    if (rstreq === 1'b1 && prev_rq === 1'b0) rise_cnt++;
    prev_rq = rstreq;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int bound, output int cycles);
    cycles = 0;
    while (busy && cycles < bound) begin
      step(1);
      cycles++;
    end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  task automatic sw_strobe(input logic [7:0] key);
    sw_rst_req = 1'b1;
    sw_rst_key = key;
    step(1);
    sw_rst_req = 1'b0;
    sw_rst_key = 8'h00;
  endtask

  initial begin
    int r0, h0, n;
    step(1);
    cmp_en = 1;
    step(2);
    check("reset_rstreq", int'(rstreq), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_cause", int'(rst_cause), 0);
    resetn = 1'b1;
    step(2);

    // Short press shorter than the debounce window.
    r0 = rise_cnt;
    btn_rstn = 1'b0; step(10);
    btn_rstn = 1'b1; step(40);
    check("short_press_pulses", rise_cnt - r0, 0);

    // Long press.
    r0 = rise_cnt; h0 = hi_cnt;
    btn_rstn = 1'b0; step(40);
    btn_rstn = 1'b1;
    wait_idle(300, n);
    check("long_press_pulses", rise_cnt - r0, 1);
    check("long_press_len", hi_cnt - h0, PL);
    check("long_press_cause", int'(rst_cause), 1);

    // Software trigger: wrong key, then right key.
    r0 = rise_cnt;
    sw_strobe(8'h5A); step(20);
    check("bad_key_pulses", rise_cnt - r0, 0);
    h0 = hi_cnt;
    check("sw_before_edge", int'(rstreq), 0);
    sw_strobe(8'hA5);
    check("sw_latency", int'(rstreq), 1);
    wait_idle(200, n);
    check("sw_busy_cycles", n, PL + 16);
    check("sw_len", hi_cnt - h0, PL);
    check("sw_cause", int'(rst_cause), 3);

    // Watchdog timeout, then regular kicks.
    step(3);
    wdt_enable = 1'b1;
    n = 0;
    while (!rstreq && n < 200) begin
      step(1);
      n++;
    end
    check("wdt_latency", n, WDT_MAX + 1);
    wdt_enable = 1'b0;
    wait_idle(200, n);
    check("wdt_cause", int'(rst_cause), 2);
    r0 = rise_cnt;
    wdt_enable = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      wdt_kick = (i % 50 == 0);
      step(1);
    end
    wdt_kick = 1'b0; wdt_enable = 1'b0;
    check("kicked_pulses", rise_cnt - r0, 0);

    // Button and software in the same cycle; sw during ASSERT; long hold.
    r0 = rise_cnt; h0 = hi_cnt;
    btn_rstn = 1'b0; step(17);
    sw_strobe(8'hA5);
    check("simul_rstreq", int'(rstreq), 1);
    check("simul_cause", int'(rst_cause), 1);
    step(2);
    sw_strobe(8'hA5);
    step(500);
    check("held_busy", int'(busy), 1);
    check("held_rstreq", int'(rstreq), 0);
    btn_rstn = 1'b1;
    wait_idle(200, n);
    check("release_to_idle", n, 2 + (1 << DB) + 16);
    step(20);
    check("simul_pulses", rise_cnt - r0, 1);
    check("simul_len", hi_cnt - h0, PL);

    // Reset asserted in the third ASSERT cycle.
    r0 = rise_cnt;
    sw_strobe(8'hA5);
    step(2);
    check("third_cycle_rstreq", int'(rstreq), 1);
    resetn = 1'b0;
    #1;
    check("async_rstreq", int'(rstreq), 0);
    check("async_busy", int'(busy), 0);
    step(3);
    resetn = 1'b1;
    step(30);
    check("post_reset_cause", int'(rst_cause), 0);
    check("post_reset_pulses", rise_cnt - r0, 1);

    // Button already held when reset releases.
    r0 = rise_cnt;
    btn_rstn = 1'b0;
    resetn = 1'b0;
    step(2);
    resetn = 1'b1;
    n = 0;
    while (!rstreq && n < 100) begin
      step(1);
      n++;
    end
    check("held_at_reset_rise", int'(rstreq), 1);
    check("held_at_reset_cause", int'(rst_cause), 1);
    btn_rstn = 1'b1;
    wait_idle(200, n);
    check("held_at_reset_pulses", rise_cnt - r0, 1);

    step(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rstreq_ctrl.md
RSTREQ_CTRL -- requirements
Module: rstreq_ctrl

Interface
REQ-001 Parameter DEBOUNCE_BITS, default 16, sets the debounce stability window to 2^DEBOUNCE_BITS clk cycles.
REQ-002 Parameter PULSE_LEN, default 8, sets the number of clk cycles rstreq is held high per request (legal range 1..255).
REQ-003 Parameter WDT_BITS, default 24, sets the watchdog counter width; timeout occurs at 2^WDT_BITS-1 cycles without a kick.
REQ-004 clk  in  1  system clock; the sole clock of the block.
REQ-005 resetn  in  1  asynchronous active-low reset; driven from the power-on/PLL-lock reset, never from the resetgen output.
REQ-006 btn_rstn  in  1  external reset button, active low, asynchronous to clk.
REQ-007 sw_rst_req  in  1  one-cycle software reset strobe.
REQ-008 sw_rst_key  in  8  key qualifying sw_rst_req.
REQ-009 wdt_enable  in  1  watchdog enable level.
REQ-010 wdt_kick  in  1  one-cycle watchdog restart strobe.
REQ-011 rstreq  out  1  reset request pulse to resetgen, active high.
REQ-012 rst_cause  out  2  cause of the last request: 00 none/power-on, 01 button, 10 watchdog, 11 software.
REQ-013 busy  out  1  high while the FSM is not IDLE.

Function
REQ-014 btn_rstn SHALL pass through a 2-flop synchroniser before any use.
REQ-015 Debounced button level SHALL change only after the synchronised level differs from it for 2^DEBOUNCE_BITS consecutive cycles; any bounce restarts the count from 0.
REQ-016 Button trigger SHALL be a one-cycle event on the debounced level's high-to-low transition.
REQ-017 Software trigger SHALL fire when sw_rst_req=1 and sw_rst_key=8'hA5 in the same cycle; any other key value is ignored without side effects.
REQ-018 Watchdog counter SHALL be held at 0 while wdt_enable=0, cleared on wdt_kick, else increment by 1 per cycle; it fires a trigger on reaching all-ones and then holds at all-ones until cleared.
REQ-019 FSM states: IDLE, ASSERT, HOLDOFF.
REQ-020 IDLE -> ASSERT on any trigger; rstreq SHALL rise the cycle after the trigger.
REQ-021 Simultaneous triggers SHALL be prioritised button > watchdog > software; only the winner is recorded.
REQ-022 rst_cause SHALL be loaded on the IDLE->ASSERT transition and hold until the next such transition.
REQ-023 ASSERT holds rstreq=1 for exactly PULSE_LEN cycles, then -> HOLDOFF with rstreq=0.
REQ-024 HOLDOFF -> IDLE only after the debounced button reads released (high) AND 16 further cycles have elapsed in HOLDOFF; a held button keeps the FSM in HOLDOFF indefinitely.
REQ-025 Triggers in ASSERT or HOLDOFF SHALL be discarded, not queued.
REQ-026 Watchdog counter SHALL be forced to 0 during ASSERT and HOLDOFF.
REQ-027 busy SHALL equal (state != IDLE).
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 On resetn=0, asynchronously: FSM=IDLE, rstreq=0, rst_cause=00, busy=0, all counters 0, debounced level and synchroniser flops=1 (released).
REQ-030 resetn asserted mid-ASSERT SHALL drop rstreq immediately; no request resumes after release.
REQ-031 After resetn deassertion, a button already held low SHALL produce a trigger once debounced (released-to-pressed transition from the reset value).

Verification
REQ-032 DEBOUNCE_BITS=4: btn_rstn low for 10 cycles then high -> no rstreq; low for 40 cycles -> rstreq high for exactly PULSE_LEN=8 cycles, rst_cause=01.
REQ-033 sw_rst_req with key 8'h5A -> no rstreq; with key 8'hA5 -> rstreq 1 cycle later for 8 cycles, rst_cause=11, busy high until HOLDOFF exits.
REQ-034 WDT_BITS=6, wdt_enable=1, no kicks -> trigger at count 63, rst_cause=10; kicks every 50 cycles -> no rstreq over 1000 cycles.
REQ-035 Button trigger and software trigger in the same cycle -> single 8-cycle pulse, rst_cause=01; software strobe during ASSERT -> no second pulse.
REQ-036 Button held 500 cycles past pulse -> FSM stays HOLDOFF, busy=1; release -> IDLE after debounce + 16 cycles, no retrigger.
REQ-037 resetn low in 3rd ASSERT cycle -> rstreq=0 same cycle, rst_cause=00 after release.
